// File: rtl/fb_pkg.sv
// Shared constants for the frame-buffer SPRAM arbiter: default bus widths,
// requester IDs used on the read-return tag, and round-robin pointer codes.
package fb_pkg;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 8;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_JWB  = 2'd1;
    localparam logic [1:0] ID_YTY  = 2'd2;
    localparam logic [1:0] ID_SPI  = 2'd3;

    // Pointer codes double as bit positions in the {SPI,YTY,JWB} req/gnt vectors
    localparam logic [1:0] PTR_JWB = 2'd0;
    localparam logic [1:0] PTR_YTY = 2'd1;
    localparam logic [1:0] PTR_SPI = 2'd2;

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Requester handshakes and SPRAM command/return bus for the frame-buffer arbiter.
// The arbiter uses the slave modport; requesters and memory sit on the master side.
interface fb_mem_arbiter_if #(
    parameter int ADDR_W = fb_pkg::FB_ADDR_W,
    parameter int DATA_W = fb_pkg::FB_DATA_W
);

    logic              cam_we;
    logic [ADDR_W-1:0] cam_addr;
    logic [DATA_W-1:0] cam_wdata;

    logic              jwb_req;
    logic [ADDR_W-1:0] jwb_addr;
    logic [DATA_W-1:0] jwb_wdata;
    logic              jwb_gnt;

    logic              yty_req;
    logic [ADDR_W-1:0] yty_addr;
    logic              yty_gnt;
    logic              yty_rvalid;

    logic              spi_req;
    logic [ADDR_W-1:0] spi_addr;
    logic              spi_gnt;
    logic              spi_rvalid;

    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    logic [2:0]        starve;

    modport slave (
        input  cam_we, cam_addr, cam_wdata,
        input  jwb_req, jwb_addr, jwb_wdata,
        input  yty_req, yty_addr,
        input  spi_req, spi_addr,
        input  mem_rdata,
        output jwb_gnt, yty_gnt, yty_rvalid, spi_gnt, spi_rvalid,
        output rd_data, mem_addr, mem_wdata, mem_we, mem_re, starve
    );

    modport master (
        output cam_we, cam_addr, cam_wdata,
        output jwb_req, jwb_addr, jwb_wdata,
        output yty_req, yty_addr,
        output spi_req, spi_addr,
        output mem_rdata,
        input  jwb_gnt, yty_gnt, yty_rvalid, spi_gnt, spi_rvalid,
        input  rd_data, mem_addr, mem_wdata, mem_we, mem_re, starve
    );

endinterface

// File: rtl/fb_rr_pick3.sv
// Combinational 3-way round-robin selector: scans req starting at ptr in the
// order JWB->YTY->SPI->JWB and returns a one-hot grant (or zero when idle).
module fb_rr_pick3
    import fb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        case (ptr)
            PTR_YTY: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            PTR_SPI: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port frame-buffer SPRAM arbiter: CAM writes always win, JWB/YTY/SPI share
// the remaining cycles round-robin; one registered command per cycle, tagged read return.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W,
    parameter int RD_LAT   = 1,
    parameter int STARVE_W = 8
) (
    input  logic              pclk,
    input  logic              reset_n,
    fb_mem_arbiter_if.slave   bus
);

    localparam logic [STARVE_W-1:0] WAIT_ONE = {{(STARVE_W-1){1'b0}}, 1'b1};

    logic [2:0]                raw_req;
    logic [2:0]                rr_req;
    logic [2:0]                gnt_v;
    logic [2:0]                waiting;

    logic [1:0]                ptr_q, ptr_d;
    logic                      mem_we_q, mem_we_d;
    logic                      mem_re_q, mem_re_d;
    logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]         mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]         rd_data_q, rd_data_d;
    logic [1:0]                tag_in;
    logic [RD_LAT:0][1:0]      tag_q, tag_d;
    logic [2:0][STARVE_W-1:0]  wait_q, wait_d;
    logic [2:0]                starve_q, starve_d;

    function automatic logic [STARVE_W-1:0] next_wait(input logic w, input logic [STARVE_W-1:0] cnt);
        if (!w)
            return '0;
        else if (&cnt)
            return cnt;
        else
            return cnt + WAIT_ONE;
    endfunction

    assign raw_req = {bus.spi_req, bus.yty_req, bus.jwb_req};
    // Grants are suppressed while reset is asserted and whenever CAM owns the cycle
    assign rr_req  = (bus.cam_we || !reset_n) ? 3'b000 : raw_req;

    fb_rr_pick3 u_pick (
        .req (rr_req),
        .ptr (ptr_q),
        .gnt (gnt_v)
    );

    always_comb begin
        ptr_d       = ptr_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag_in      = ID_NONE;
        if (bus.cam_we) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.cam_addr;
            mem_wdata_d = bus.cam_wdata;
        end else if (gnt_v[0]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.jwb_addr;
            mem_wdata_d = bus.jwb_wdata;
            ptr_d       = PTR_YTY;
        end else if (gnt_v[1]) begin
            mem_re_d    = 1'b1;
            mem_addr_d  = bus.yty_addr;
            tag_in      = ID_YTY;
            ptr_d       = PTR_SPI;
        end else if (gnt_v[2]) begin
            mem_re_d    = 1'b1;
            mem_addr_d  = bus.spi_addr;
            tag_in      = ID_SPI;
            ptr_d       = PTR_JWB;
        end
    end

    // Read data is captured in the cycle its tag is one stage from the output
    always_comb begin
        tag_d     = {tag_q[RD_LAT-1:0], tag_in};
        rd_data_d = rd_data_q;
        if (tag_q[RD_LAT-1] != ID_NONE)
            rd_data_d = bus.mem_rdata;
    end

    always_comb begin
        waiting   = raw_req & ~gnt_v;
        wait_d[0] = next_wait(waiting[0], wait_q[0]);
        wait_d[1] = next_wait(waiting[1], wait_q[1]);
        wait_d[2] = next_wait(waiting[2], wait_q[2]);
        starve_d  = starve_q | (waiting & {&wait_q[2], &wait_q[1], &wait_q[0]});
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= PTR_JWB;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            tag_q       <= '0;
            wait_q      <= '0;
            starve_q    <= 3'b000;
        end else begin
            ptr_q       <= ptr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            tag_q       <= tag_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
        end
    end

    assign bus.jwb_gnt    = gnt_v[0];
    assign bus.yty_gnt    = gnt_v[1];
    assign bus.spi_gnt    = gnt_v[2];
    assign bus.yty_rvalid = (tag_q[RD_LAT] == ID_YTY);
    assign bus.spi_rvalid = (tag_q[RD_LAT] == ID_SPI);
    assign bus.rd_data    = rd_data_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.starve     = starve_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter: directed scenarios plus a randomized run
// checked against a queue-based behavioural model of arbitration, commands and returns.
module tb_fb_mem_arbiter;
    import fb_pkg::*;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 8;
    localparam int RD_LAT   = 1;
    localparam int STARVE_W = 8;

    typedef struct {
        int             due;
        int             who;
        logic [7:0]     data;
    } ret_t;

    logic       pclk;
    logic       reset_n;
    logic       use_model;
    logic [7:0] manual_rdata;
    int         tests_run;
    int         fails;

    fb_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .STARVE_W (STARVE_W)
    ) dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory stand-in: asynchronous read whose contents are a fixed function of the address
    assign bus.mem_rdata = use_model ? (bus.mem_addr[7:0] ^ 8'h5A) : manual_rdata;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [2:0] gnts();
        return {bus.spi_gnt, bus.yty_gnt, bus.jwb_gnt};
    endfunction

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.cam_we    = 1'b0;
        bus.cam_addr  = '0;
        bus.cam_wdata = '0;
        bus.jwb_req   = 1'b0;
        bus.jwb_addr  = '0;
        bus.jwb_wdata = '0;
        bus.yty_req   = 1'b0;
        bus.yty_addr  = '0;
        bus.spi_req   = 1'b0;
        bus.spi_addr  = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.jwb_req = 1'b1;
        bus.yty_req = 1'b1;
        bus.spi_req = 1'b1;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (gnts() !== 3'b000) begin
            fails++;
            $display("[TB] FAIL reset_gnt got=%b exp=000", gnts());
        end
        tick();
        tick();
        #1;
        tests_run++;
        if ({bus.mem_we, bus.mem_re, bus.yty_rvalid, bus.spi_rvalid, bus.starve, bus.rd_data, bus.mem_addr} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs we=%b re=%b yv=%b sv=%b starve=%b rd=%h addr=%h exp all 0",
                     bus.mem_we, bus.mem_re, bus.yty_rvalid, bus.spi_rvalid, bus.starve, bus.rd_data, bus.mem_addr);
        end
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (gnts() !== 3'b001) begin
            fails++;
            $display("[TB] FAIL reset_first_jwb got=%b exp=001", gnts());
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_rr_order();
        int              order[6] = '{0, 1, 2, 0, 1, 2};
        logic [16:0]     addrs[3] = '{17'h00100, 17'h00200, 17'h00300};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            bus.jwb_req   = (c < 6);
            bus.yty_req   = (c < 6);
            bus.spi_req   = (c < 6);
            bus.jwb_addr  = addrs[0];
            bus.jwb_wdata = 8'h11;
            bus.yty_addr  = addrs[1];
            bus.spi_addr  = addrs[2];
            #1;
            tests_run++;
            if (c < 6 && gnts() !== (3'b001 << order[c])) begin
                fails++;
                $display("[TB] FAIL rr_order c=%0d got=%b exp=%b", c, gnts(), 3'b001 << order[c]);
            end else if (c == 6 && gnts() !== 3'b000) begin
                fails++;
                $display("[TB] FAIL rr_idle got=%b exp=000", gnts());
            end
            if (c > 0) begin
                tests_run++;
                if (bus.mem_we !== (order[c-1] == 0) || bus.mem_re !== (order[c-1] != 0) ||
                    bus.mem_addr !== addrs[order[c-1]]) begin
                    fails++;
                    $display("[TB] FAIL rr_cmd c=%0d we=%b re=%b addr=%h exp we=%b re=%b addr=%h", c,
                             bus.mem_we, bus.mem_re, bus.mem_addr,
                             order[c-1] == 0, order[c-1] != 0, addrs[order[c-1]]);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_read_return();
        apply_reset();
        use_model    = 1'b0;
        manual_rdata = 8'h00;
        bus.yty_req  = 1'b1;
        bus.yty_addr = 17'h00010;
        #1;
        tests_run++;
        if (gnts() !== 3'b010) begin
            fails++;
            $display("[TB] FAIL read_gnt got=%b exp=010", gnts());
        end
        tick();
        bus.yty_req = 1'b0;
        for (int c = 1; c <= RD_LAT + 1; c++) begin
            manual_rdata = (c >= RD_LAT) ? 8'hA5 : 8'h00;
            #1;
            if (c == 1) begin
                tests_run++;
                if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 17'h00010) begin
                    fails++;
                    $display("[TB] FAIL read_cmd re=%b we=%b addr=%h exp re=1 we=0 addr=00010",
                             bus.mem_re, bus.mem_we, bus.mem_addr);
                end
            end
            if (c <= RD_LAT) begin
                tests_run++;
                if ({bus.yty_rvalid, bus.spi_rvalid} !== 2'b00) begin
                    fails++;
                    $display("[TB] FAIL read_early c=%0d rvalid=%b exp=00", c, {bus.yty_rvalid, bus.spi_rvalid});
                end
            end else begin
                tests_run++;
                if (bus.yty_rvalid !== 1'b1 || bus.spi_rvalid !== 1'b0 || bus.rd_data !== 8'hA5) begin
                    fails++;
                    $display("[TB] FAIL read_return yv=%b sv=%b rd=%h exp yv=1 sv=0 rd=a5",
                             bus.yty_rvalid, bus.spi_rvalid, bus.rd_data);
                end
            end
            tick();
        end
        manual_rdata = 8'h00;
        #1;
        tests_run++;
        if ({bus.yty_rvalid, bus.spi_rvalid} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL read_single_cycle rvalid=%b exp=00", {bus.yty_rvalid, bus.spi_rvalid});
        end
        tick();
        use_model = 1'b1;
    endtask

    task automatic test_cam_priority();
        apply_reset();
        bus.cam_we    = 1'b1;
        bus.cam_addr  = 17'h1F3FF;
        bus.cam_wdata = 8'h3C;
        bus.jwb_req   = 1'b1;
        bus.yty_req   = 1'b1;
        bus.spi_req   = 1'b1;
        bus.jwb_addr  = 17'h00042;
        bus.jwb_wdata = 8'h77;
        #1;
        tests_run++;
        if (gnts() !== 3'b000) begin
            fails++;
            $display("[TB] FAIL cam_blocks got=%b exp=000", gnts());
        end
        tick();
        bus.cam_we = 1'b0;
        #1;
        tests_run++;
        if (gnts() !== 3'b001) begin
            fails++;
            $display("[TB] FAIL cam_ptr_kept got=%b exp=001", gnts());
        end
        tests_run++;
        if ({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 17'h1F3FF, 8'h3C}) begin
            fails++;
            $display("[TB] FAIL cam_cmd we=%b re=%b addr=%h wd=%h exp we=1 re=0 addr=1f3ff wd=3c",
                     bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        bus.jwb_req = 1'b0;
        #1;
        tests_run++;
        if ({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 17'h00042, 8'h77}) begin
            fails++;
            $display("[TB] FAIL jwb_cmd we=%b re=%b addr=%h wd=%h exp we=1 re=0 addr=00042 wd=77",
                     bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata);
        end
        tests_run++;
        if (gnts() !== 3'b010) begin
            fails++;
            $display("[TB] FAIL cam_then_yty got=%b exp=010", gnts());
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_starve();
        apply_reset();
        bus.spi_req  = 1'b1;
        bus.spi_addr = 17'h00777;
        for (int k = 1; k <= (1 << STARVE_W); k++) begin
            bus.cam_we    = 1'b1;
            bus.cam_addr  = 17'(k);
            bus.cam_wdata = 8'(k);
            #1;
            if (k == (1 << STARVE_W)) begin
                tests_run++;
                if (bus.starve !== 3'b000) begin
                    fails++;
                    $display("[TB] FAIL starve_early k=%0d got=%b exp=000", k, bus.starve);
                end
            end
            tick();
        end
        bus.cam_we = 1'b0;
        #1;
        tests_run++;
        if (bus.starve !== 3'b100 || gnts() !== 3'b100) begin
            fails++;
            $display("[TB] FAIL starve_set starve=%b gnt=%b exp starve=100 gnt=100", bus.starve, gnts());
        end
        tick();
        clear_inputs();
        tick();
        tick();
        #1;
        tests_run++;
        if (bus.starve !== 3'b100) begin
            fails++;
            $display("[TB] FAIL starve_sticky got=%b exp=100", bus.starve);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        bus.yty_req  = 1'b1;
        bus.yty_addr = 17'h00021;
        #1;
        tests_run++;
        if (gnts() !== 3'b010) begin
            fails++;
            $display("[TB] FAIL midrst_yty got=%b exp=010", gnts());
        end
        tick();
        bus.yty_req  = 1'b0;
        bus.spi_req  = 1'b1;
        bus.spi_addr = 17'h00022;
        #1;
        tests_run++;
        if (gnts() !== 3'b100) begin
            fails++;
            $display("[TB] FAIL midrst_spi got=%b exp=100", gnts());
        end
        tick();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < RD_LAT + 3; c++) begin
            #1;
            tests_run++;
            if ({bus.yty_rvalid, bus.spi_rvalid} !== 2'b00) begin
                fails++;
                $display("[TB] FAIL midrst_rvalid c=%0d got=%b exp=00", c, {bus.yty_rvalid, bus.spi_rvalid});
            end
            tick();
        end
        bus.jwb_req = 1'b1;
        bus.yty_req = 1'b1;
        bus.spi_req = 1'b1;
        #1;
        tests_run++;
        if (gnts() !== 3'b001) begin
            fails++;
            $display("[TB] FAIL midrst_ptr got=%b exp=001", gnts());
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        int          ptr;
        int          win;
        int          wcnt[3];
        logic [2:0]  starve_m;
        logic        exp_we, exp_re;
        logic [16:0] exp_addr;
        logic [7:0]  exp_wdata;
        logic [2:0]  req;
        logic        cam;
        logic [16:0] ca;
        logic [7:0]  cw, jw;
        logic [16:0] addr[3];
        logic [1:0]  exp_rv;
        logic [7:0]  exp_rd;
        ret_t        q[$];

        apply_reset();
        use_model = 1'b1;
        ptr = 0;
        wcnt = '{0, 0, 0};
        starve_m = 3'b000;
        exp_we = 1'b0;
        exp_re = 1'b0;
        exp_addr = '0;
        exp_wdata = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cam = ($urandom_range(3) == 0);
            req = 3'($urandom_range(7));
            ca  = 17'($urandom);
            cw  = 8'($urandom);
            jw  = 8'($urandom);
            for (int i = 0; i < 3; i++) addr[i] = 17'($urandom);
            bus.cam_we    = cam;
            bus.cam_addr  = ca;
            bus.cam_wdata = cw;
            bus.jwb_req   = req[0];
            bus.jwb_addr  = addr[0];
            bus.jwb_wdata = jw;
            bus.yty_req   = req[1];
            bus.yty_addr  = addr[1];
            bus.spi_req   = req[2];
            bus.spi_addr  = addr[2];
            #1;

            win = -1;
            if (!cam) begin
                for (int k = 0; k < 3; k++) begin
                    int idx;
                    idx = (ptr + k) % 3;
                    if (win < 0 && req[idx[1:0]]) win = idx;
                end
            end
            tests_run++;
            if (gnts() !== ((win < 0) ? 3'b000 : (3'b001 << win))) begin
                fails++;
                $display("[TB] FAIL rand_gnt cyc=%0d got=%b exp_winner=%0d", cyc, gnts(), win);
            end
            tests_run++;
            if ({bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata} !== {exp_we, exp_re, exp_addr, exp_wdata}) begin
                fails++;
                $display("[TB] FAIL rand_cmd cyc=%0d got we=%b re=%b a=%h d=%h exp we=%b re=%b a=%h d=%h", cyc,
                         bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, exp_we, exp_re, exp_addr, exp_wdata);
            end
            exp_rv = 2'b00;
            exp_rd = 8'h00;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_rv = (q[0].who == 1) ? 2'b10 : 2'b01;
                exp_rd = q[0].data;
                void'(q.pop_front());
            end
            tests_run++;
            if ({bus.yty_rvalid, bus.spi_rvalid} !== exp_rv) begin
                fails++;
                $display("[TB] FAIL rand_rvalid cyc=%0d got=%b exp=%b", cyc, {bus.yty_rvalid, bus.spi_rvalid}, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                tests_run++;
                if (bus.rd_data !== exp_rd) begin
                    fails++;
                    $display("[TB] FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, bus.rd_data, exp_rd);
                end
            end
            tests_run++;
            if (bus.starve !== starve_m) begin
                fails++;
                $display("[TB] FAIL rand_starve cyc=%0d got=%b exp=%b", cyc, bus.starve, starve_m);
            end

            exp_we = 1'b0;
            exp_re = 1'b0;
            if (cam) begin
                exp_we = 1'b1;
                exp_addr = ca;
                exp_wdata = cw;
            end else if (win == 0) begin
                exp_we = 1'b1;
                exp_addr = addr[0];
                exp_wdata = jw;
            end else if (win > 0) begin
                exp_re = 1'b1;
                exp_addr = addr[win];
                q.push_back('{due: cyc + 1 + RD_LAT, who: win, data: addr[win][7:0] ^ 8'h5A});
            end
            if (win >= 0) ptr = (win + 1) % 3;
            for (int i = 0; i < 3; i++) begin
                if (req[i] && win != i) begin
                    wcnt[i]++;
                    if (wcnt[i] >= (1 << STARVE_W)) starve_m[i] = 1'b1;
                end else begin
                    wcnt[i] = 0;
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        tests_run    = 0;
        fails        = 0;
        reset_n      = 1'b1;
        use_model    = 1'b1;
        manual_rdata = 8'h00;
        clear_inputs();
        #1;
        test_reset();
        test_rr_order();
        test_read_return();
        test_cam_priority();
        test_starve();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
